ram_banked: RTL and testbench
=============================

# ram_banked

Parametrised successor to the fixed 512×8 hierarchical RAM. It is a single-port banked RAM with width, depth and bank count set by parameters. It adds a valid/ready request port, a registered read response with fixed 1-cycle latency, and a hardware clear engine that zero-fills all banks in parallel. It sits between the CPU data path and storage and replaces hand-instantiated RAM trees.

## Interface
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 9: total address width; depth = 2^ADDR_W.
- `BANK_SEL_W`, default 3: upper address bits that select the bank; banks = 2^BANK_SEL_W, bank depth = 2^(ADDR_W-BANK_SEL_W).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request can be accepted; equals (state == IDLE).
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  word address; `[ADDR_W-1 -: BANK_SEL_W]` selects the bank, the low bits select the word within the bank.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  read data valid; 1-cycle pulse.
- `rsp_rdata`  out  DATA_W  read data; holds its last value between reads.
- `clear_start`  in  1  begin a zero-fill of the whole memory.
- `clear_busy`  out  1  clear in progress.
- `clear_done`  out  1  1-cycle pulse after the last clear write.

## Operation
- A request is accepted when `req_valid && req_ready` at a clock edge.
- Write: only the selected bank's write enable is asserted; the other banks are untouched. No response is generated.
- Read: the addressed word is registered into `rsp_rdata`, and `rsp_valid`=1 on the next cycle.
- A read accepted in the cycle after a write to the same address returns the new data.
- FSM states are IDLE and CLEAR.
- IDLE→CLEAR on `clear_start`. A request accepted in the same cycle as `clear_start` executes normally, and clearing starts on the next cycle.
- In CLEAR, a shared row counter `clr_idx` (width ADDR_W-BANK_SEL_W) runs 0..bank depth-1. Every cycle, all banks write 0 at `clr_idx` in parallel.
- CLEAR→IDLE after the cycle that writes `clr_idx` = max. `clear_done` pulses on the first IDLE cycle.
- `clear_start` is ignored while in CLEAR (no restart or extension).
- `req_ready`=0 throughout CLEAR, so no requests are accepted and `rsp_valid` stays 0.
- `rst_n` resets control state only; memory contents are not reset.

## Timing
- Reset values: state=IDLE, `clr_idx`=0, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `clear_busy`=0, `clear_done`=0.
- Read latency is exactly 1 cycle from acceptance. Throughput is one request per cycle.
- `clear_busy` goes high on the cycle after `clear_start` is sampled and stays high for exactly 2^(ADDR_W-BANK_SEL_W) cycles.
- Clearing takes 64 cycles at default parameters.
- Reset asserted mid-clear aborts immediately: state=IDLE, `clear_busy`=0, no `clear_done` pulse. Memory is left partially cleared.
- Reset asserted in the cycle after a read acceptance suppresses `rsp_valid`.

## Structure
- A shared package/header `ram_defs` holds the default DATA_W, ADDR_W and BANK_SEL_W, and the FSM state encodings (IDLE=0, CLEAR=1).
- One sub-module, `ram_bank`: a synchronous-write memory of depth 2^(ADDR_W-BANK_SEL_W) with parameters DATA_W and the bank address width, and ports `clk`, `we`, `addr`, `wdata`, `rdata`.
- The top level instantiates the banks with a generate loop, plus the bank-select decode, the write-path mux (request vs. clear), the output mux, the FSM and the response register.

## Test plan
- Reset, then write 0xA5 @ 0x000 and 0x3C @ 0x1FF, then read both → `rsp_valid` one cycle after each read; data 0xA5 and 0x3C.
- Write 0x11 @ 0x040 (bank 1, row 0), then read 0x000 (bank 0, row 0) → bank 0 unchanged; 0x040 reads back 0x11.
- Back-to-back write 0x77 @ 0x055, then read 0x055 the next cycle → 0x77 is returned.
- Fill all 512 words with nonzero data, pulse `clear_start` → `clear_busy` high for 64 cycles, `req_ready`=0 throughout, `clear_done` pulses once; afterwards every address reads 0x00, and a `clear_start` issued mid-clear has no effect on the timing.
- Start a clear, assert `rst_n`=0 at cycle 10 → all outputs reach reset values asynchronously, no `clear_done`; rows 0–9 read 0, row 40 retains its old data.
- Parameter sweep: DATA_W=16, ADDR_W=12, BANK_SEL_W=2 → read/write and clear (1024 cycles) pass the checks above.

Source files
------------

// File: rtl/ram_banked_pkg.sv
// Shared definitions for the banked RAM: default geometry and FSM state encodings.
package ram_defs;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_BANK_SEL_W = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/ram_banked_bank.sv
// One storage bank: synchronous write, combinational read. Contents are never reset.
module ram_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [1 << ADDR_W];

  // Store the write word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/ram_banked.sv
// Single-port banked RAM with valid/ready requests, a registered 1-cycle read
// response and a clear engine that zero-fills every bank in parallel.
module ram_banked
  import ram_defs::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BANK_SEL_W = DEF_BANK_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int ROW_W = ADDR_W - BANK_SEL_W;
  localparam int NBANK = 1 << BANK_SEL_W;
  localparam logic [ROW_W-1:0] ROW_LAST = '1;
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  logic [0:0]        r_state;
  logic [ROW_W-1:0]  r_clr_idx;
  logic              r_clear_done;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic                  w_idle;
  logic                  w_clearing;
  logic                  w_accept;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [BANK_SEL_W-1:0] w_sel;
  logic [ROW_W-1:0]      w_row;
  logic [ROW_W-1:0]      w_bank_addr;
  logic [DATA_W-1:0]     w_bank_wdata;
  logic [NBANK-1:0]      w_bank_we;
  logic [DATA_W-1:0]     w_bank_rdata [NBANK];
  logic [DATA_W-1:0]     w_rd_data;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_accept    = req_valid && w_idle;
  assign w_wr_accept = w_accept && req_we;
  assign w_rd_accept = w_accept && !req_we;

  assign w_sel = req_addr[ADDR_W-1 -: BANK_SEL_W];
  assign w_row = req_addr[ROW_W-1:0];

  // The clear engine owns the shared write path while clearing; requests cannot arrive then
  assign w_bank_addr  = w_clearing ? r_clr_idx : w_row;
  assign w_bank_wdata = w_clearing ? '0 : req_wdata;

  generate
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
      assign w_bank_we[b] = w_clearing || (w_wr_accept && (w_sel == BANK_SEL_W'(b)));
      ram_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ROW_W)
      ) u_bank (
        .clk   (clk),
        .we    (w_bank_we[b]),
        .addr  (w_bank_addr),
        .wdata (w_bank_wdata),
        .rdata (w_bank_rdata[b])
      );
    end
  endgenerate

  assign w_rd_data = w_bank_rdata[w_sel];

  // Control FSM: IDLE serves requests, CLEAR walks every row once then returns and pulses done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_clr_idx    <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_start) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
          end
        end
        default: begin
          if (r_clr_idx == ROW_LAST) begin
            r_state      <= ST_IDLE;
            r_clr_idx    <= '0;
            r_clear_done <= 1'b1;
          end else begin
            r_clr_idx <= r_clr_idx + ROW_ONE;
          end
        end
      endcase
    end
  end

  // Read response register: pulse valid for one cycle, hold data between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd_accept;
      if (w_rd_accept) r_rsp_rdata <= w_rd_data;
    end
  end

  assign req_ready  = w_idle;
  assign clear_busy = w_clearing;
  assign clear_done = r_clear_done;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;

endmodule

// File: tb/tb_ram_banked.sv
// Directed bench for ram_banked: default geometry plus a 16-bit/4-bank/4096-word instance.
module tb_ram_banked;

  logic clk;
  logic rst_n;

  // Default-geometry instance signals
  logic       req_valid, req_we, clear_start;
  logic [8:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid, clear_busy, clear_done;
  logic [7:0] rsp_rdata;

  // Wide-geometry instance signals
  logic        req_valid2, req_we2, clear_start2;
  logic [11:0] req_addr2;
  logic [15:0] req_wdata2;
  logic        req_ready2, rsp_valid2, clear_busy2, clear_done2;
  logic [15:0] rsp_rdata2;

  int n_checks = 0;
  int n_errs   = 0;

  ram_banked u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done)
  );

  ram_banked #(
    .DATA_W     (16),
    .ADDR_W     (12),
    .BANK_SEL_W (2)
  ) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid2),
    .req_ready   (req_ready2),
    .req_we      (req_we2),
    .req_addr    (req_addr2),
    .req_wdata   (req_wdata2),
    .rsp_valid   (rsp_valid2),
    .rsp_rdata   (rsp_rdata2),
    .clear_start (clear_start2),
    .clear_busy  (clear_busy2),
    .clear_done  (clear_done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Nonzero fill pattern used for the full-memory clear test
  function automatic logic [7:0] fill_val(input int a);
    return 8'((a % 255) + 1);
  endfunction

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic v, output logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    v = rsp_valid;
    d = rsp_rdata;
  endtask

  task automatic rd_chk(input string tag, input logic [8:0] a, input logic [7:0] exp);
    logic       v;
    logic [7:0] d;
    rd(a, v, d);
    check({tag, "_vld"}, 32'(v), 32'd1);
    check({tag, "_data"}, 32'(d), 32'(exp));
  endtask

  task automatic wr2(input logic [11:0] a, input logic [15:0] d);
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = a; req_wdata2 = d;
    tick();
    req_valid2 = 1'b0; req_we2 = 1'b0;
  endtask

  task automatic rd2_chk(input string tag, input logic [11:0] a, input logic [15:0] exp);
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = a;
    tick();
    req_valid2 = 1'b0;
    check({tag, "_vld"}, 32'(rsp_valid2), 32'd1);
    check({tag, "_data"}, 32'(rsp_rdata2), 32'(exp));
  endtask

  initial begin
    int         n;
    int         done_cnt;
    int         bad;
    logic       v;
    logic [7:0] d;

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; clear_start2 = 1'b0;

    // Reset values
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_ready2", 32'(req_ready2), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic write/read at both ends of the address space
    wr(9'h000, 8'hA5);
    wr(9'h1FF, 8'h3C);
    rd_chk("rd_000", 9'h000, 8'hA5);
    rd_chk("rd_1ff", 9'h1FF, 8'h3C);
    tick();
    check("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
    check("rsp_rdata_hold", 32'(rsp_rdata), 32'h3C);

    // Bank isolation: bank 1 row 0 write leaves bank 0 row 0 intact
    wr(9'h040, 8'h11);
    rd_chk("iso_000", 9'h000, 8'hA5);
    rd_chk("iso_040", 9'h040, 8'h11);

    // Read in the cycle right after a write to the same address
    wr(9'h055, 8'h77);
    rd_chk("raw_055", 9'h055, 8'h77);

    // Fill the whole memory with nonzero data
    for (int a = 0; a < 512; a++) wr(9'(a), fill_val(a));

    // Read accepted together with clear_start executes, then clear begins
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h100; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("clr_start_rd_vld", 32'(rsp_valid), 32'd1);
    check("clr_start_rd_data", 32'(rsp_rdata), 32'(fill_val(256)));
    check("clr_busy_rise", 32'(clear_busy), 32'd1);

    // Hold a write request during the clear; it must never be accepted
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h010; req_wdata = 8'hFF;
    n = 0; done_cnt = 0; bad = 0;
    while (clear_busy && n < 200) begin
      if (req_ready !== 1'b0) bad++;
      if (n > 0 && rsp_valid !== 1'b0) bad++;
      clear_start = (n == 20);
      tick();
      n++;
      if (clear_done) done_cnt++;
    end
    req_valid = 1'b0; req_we = 1'b0; clear_start = 1'b0;
    check("clr_busy_cycles", 32'(n), 32'd64);
    check("clr_ready_low", 32'(bad), 32'd0);
    check("clr_done_pulse", 32'(done_cnt), 32'd1);
    check("clr_ready_back", 32'(req_ready), 32'd1);
    tick();
    check("clr_done_once", 32'(clear_done), 32'd0);

    bad = 0;
    for (int a = 0; a < 512; a++) begin
      rd(9'(a), v, d);
      if (v !== 1'b1 || d !== 8'h00) bad++;
    end
    check("clr_all_zero", 32'(bad), 32'd0);

    // Reset mid-clear: rows 0..9 cleared, later rows keep their data
    for (int a = 0; a < 64; a++) wr(9'(a), 8'h5A);
    wr(9'h1C5, 8'h5A);
    wr(9'h1E8, 8'h5A);
    rd_chk("pre_abort_rd", 9'h028, 8'h5A);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("abort_busy_rise", 32'(clear_busy), 32'd1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(clear_busy), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_done", 32'(clear_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_no_done", 32'(clear_done), 32'd0);
    check("abort_idle", 32'(clear_busy), 32'd0);
    bad = 0;
    for (int a = 0; a < 10; a++) begin
      rd(9'(a), v, d);
      if (v !== 1'b1 || d !== 8'h00) bad++;
    end
    check("abort_rows_0_9", 32'(bad), 32'd0);
    rd_chk("abort_row10", 9'h00A, 8'h5A);
    rd_chk("abort_row40", 9'h028, 8'h5A);
    rd_chk("abort_b7_row5", 9'h1C5, 8'h00);
    rd_chk("abort_b7_row40", 9'h1E8, 8'h5A);

    // Reset in the cycle after a read acceptance kills the response
    req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h028;
    tick();
    req_valid = 1'b0;
    check("rst_rsp_pre", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rsp_kill", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Wide geometry: 16-bit words, 4 banks of 1024 rows
    wr2(12'hC05, 16'hBEEF);
    wr2(12'h005, 16'h1234);
    wr2(12'h405, 16'hA1A1);
    rd2_chk("w_rd_c05", 12'hC05, 16'hBEEF);
    rd2_chk("w_rd_005", 12'h005, 16'h1234);
    rd2_chk("w_rd_405", 12'h405, 16'hA1A1);
    wr2(12'h7FF, 16'h4321);
    rd2_chk("w_raw_7ff", 12'h7FF, 16'h4321);

    clear_start2 = 1'b1;
    tick();
    clear_start2 = 1'b0;
    n = 0; done_cnt = 0; bad = 0;
    while (clear_busy2 && n < 2000) begin
      if (req_ready2 !== 1'b0) bad++;
      clear_start2 = (n == 500);
      tick();
      n++;
      if (clear_done2) done_cnt++;
    end
    clear_start2 = 1'b0;
    check("w_clr_cycles", 32'(n), 32'd1024);
    check("w_clr_ready_low", 32'(bad), 32'd0);
    check("w_clr_done", 32'(done_cnt), 32'd1);
    rd2_chk("w_clr_c05", 12'hC05, 16'h0000);
    rd2_chk("w_clr_7ff", 12'h7FF, 16'h0000);
    rd2_chk("w_clr_005", 12'h005, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
